// File: rtl/uart_tx_fifo.sv
// Byte queue feeding the UART transmitter; drain FSM launches one frame per byte when tx idle.
// Latency: write into empty FIFO with idle transmitter -> tx_start two cycles later.
// Backpressure: writes to a full FIFO are dropped unless a pop happens the same cycle;
// UART_TX_FIFO_OVERFLOW_FLAG_EN adds a sticky overflow flag.
module uart_tx_fifo #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  clear_overflow,
    output logic                  overflow
);

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_WAIT} state_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    state_t                state_q;
    logic                  tx_start_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  push, pop, drop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH[ADDR_WIDTH:0]);
    assign count    = count_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

    // A pop frees a slot in the same edge, so a write at full is still accepted then.
    always_comb begin
        pop      = (state_q == ST_IDLE) && !empty && !tx_busy;
        push     = wr_en && (!full || pop);
        drop     = wr_en && full && !pop;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= mem_q[rd_ptr_q];
                        state_q    <= ST_ARM;
                    end else begin
                        tx_start_q <= 1'b0;
                    end
                end
                // Gives the transmitter one cycle to raise tx_busy before we watch it.
                ST_ARM: begin
                    tx_start_q <= 1'b0;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    tx_start_q <= 1'b0;
                    if (!tx_busy) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    tx_start_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
    logic overflow_q;

    // Set has priority over clear so a drop in the clearing cycle is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (clear_overflow) begin
            overflow_q <= 1'b0;
        end
    end

    assign overflow = overflow_q;
`else
    logic unused_sigs;
    assign unused_sigs = clear_overflow ^ drop;
    assign overflow    = 1'b0;
`endif

endmodule
